// File: rtl/square_click_decoder.sv
// rtl/square_click_decoder.sv - cursor-to-square hit test with press/release click qualification
module square_click_decoder #(
   parameter int unsigned ORIGIN_0        = 10,
   parameter int unsigned ORIGIN_1        = 32,
   parameter int unsigned ORIGIN_2        = 54,
   parameter int unsigned SQ_SIZE         = 20,
   parameter int unsigned BUFFER_SQUARE_X = 76,
   parameter int unsigned BUFFER_SQUARE_Y = 10,
   parameter int unsigned HOLDOFF_CYCLES  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [6:0] cursor_x,
   input  logic [6:0] cursor_y,
   input  logic       btn_left,
   output logic [4:0] hover_square,
   output logic       hover_valid,
   output logic       select_valid,
   output logic [4:0] select_square,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CANCEL  = 2'd2,
      S_HOLDOFF = 2'd3
   } state_t;

   localparam logic [4:0]  NO_SQUARE  = 5'd31;
   localparam logic [4:0]  BUF_SQUARE = 5'd9;
   localparam logic [7:0]  SQ8        = 8'(SQ_SIZE);
   localparam logic [7:0]  ORG0       = 8'(ORIGIN_0);
   localparam logic [7:0]  ORG1       = 8'(ORIGIN_1);
   localparam logic [7:0]  ORG2       = 8'(ORIGIN_2);
   localparam logic [7:0]  BUF_X      = 8'(BUFFER_SQUARE_X);
   localparam logic [7:0]  BUF_Y      = 8'(BUFFER_SQUARE_Y);
   localparam logic [15:0] HOLD_LOAD  = 16'(HOLDOFF_CYCLES - 1);

   // Widened to 8 bits so origin + size never wraps at the top of the 7-bit range.
   function automatic logic in_span(input logic [7:0] v, input logic [7:0] org);
      return (v >= org) && (v <= org + SQ8 - 8'd1);
   endfunction

   logic [7:0]  x8, y8;
   logic [2:0]  col_hit, row_hit;
   logic [1:0]  col_idx, row_idx;
   logic [4:0]  hover_d;

   state_t      state_q, state_d;
   logic [4:0]  hover_q, armed_q, armed_d, select_q;
   logic        hover_valid_q, btn_prev, select_valid_q;
   logic [15:0] cnt_q, cnt_d;
   logic        rise, fall, fire;

   assign x8 = {1'b0, cursor_x};
   assign y8 = {1'b0, cursor_y};

   always_comb begin
      col_hit = {in_span(x8, ORG2), in_span(x8, ORG1), in_span(x8, ORG0)};
      row_hit = {in_span(y8, ORG2), in_span(y8, ORG1), in_span(y8, ORG0)};
      col_idx = col_hit[0] ? 2'd0 : (col_hit[1] ? 2'd1 : 2'd2);
      row_idx = row_hit[0] ? 2'd0 : (row_hit[1] ? 2'd1 : 2'd2);
      hover_d = NO_SQUARE;
      if ((|col_hit) && (|row_hit))
         hover_d = ({3'b0, row_idx} << 1) + {3'b0, row_idx} + {3'b0, col_idx};
      else if (in_span(x8, BUF_X) && in_span(y8, BUF_Y))
         hover_d = BUF_SQUARE;
   end

   assign rise = btn_left & ~btn_prev;
   assign fall = ~btn_left & btn_prev;

   always_comb begin
      state_d = state_q;
      armed_d = armed_q;
      cnt_d   = cnt_q;
      fire    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rise) begin
               if (hover_valid_q) begin
                  state_d = S_ARMED;
                  armed_d = hover_q;
               end else begin
                  state_d = S_CANCEL;
               end
            end
         end
         S_ARMED: begin
            // Leaving the square wins over a release seen in the same cycle.
            if (hover_q != armed_q) begin
               state_d = S_CANCEL;
            end else if (fall) begin
               fire    = 1'b1;
               cnt_d   = HOLD_LOAD;
               state_d = S_HOLDOFF;
            end
         end
         S_CANCEL: begin
            if (!btn_left)
               state_d = S_IDLE;
         end
         S_HOLDOFF: begin
            if (cnt_q == 16'd0)
               state_d = btn_left ? S_CANCEL : S_IDLE;
            else
               cnt_d = cnt_q - 16'd1;
         end
         default: state_d = S_IDLE;
      endcase
      if (!enable) begin
         state_d = S_IDLE;
         fire    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hover_q        <= NO_SQUARE;
         hover_valid_q  <= 1'b0;
         btn_prev       <= 1'b1;
         state_q        <= S_IDLE;
         armed_q        <= NO_SQUARE;
         cnt_q          <= 16'd0;
         select_valid_q <= 1'b0;
         select_q       <= NO_SQUARE;
      end else begin
         hover_q        <= hover_d;
         hover_valid_q  <= (hover_d != NO_SQUARE);
         btn_prev       <= btn_left;
         state_q        <= state_d;
         armed_q        <= armed_d;
         cnt_q          <= cnt_d;
         select_valid_q <= fire;
         if (fire)
            select_q <= armed_q;
      end
   end

   assign hover_square  = hover_q;
   assign hover_valid   = hover_valid_q;
   assign select_valid  = select_valid_q;
   assign select_square = select_q;
   assign state         = state_q;

endmodule

// File: tb/tb_square_click_decoder.sv
// tb/tb_square_click_decoder.sv - directed vectors and click sequences for square_click_decoder
module tb_square_click_decoder;

   logic       clk = 1'b0;
   logic       reset, enable, btn_left;
   logic [6:0] cursor_x, cursor_y;
   logic [4:0] hover_square, select_square;
   logic       hover_valid, select_valid;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   logic sv_prev = 1'b0;

   typedef struct {
      logic [6:0] x;
      logic [6:0] y;
      logic [4:0] sq;
   } hv_vec_t;

   hv_vec_t vecs[14];

   square_click_decoder dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cursor_x(cursor_x), .cursor_y(cursor_y), .btn_left(btn_left),
      .hover_square(hover_square), .hover_valid(hover_valid),
      .select_valid(select_valid), .select_square(select_square),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Single clock advancer; also tallies pulses and guards against back-to-back pulses.
   task automatic tick();
      @(posedge clk);
      #1;
      if (select_valid) begin
         pulses++;
         chk("select_valid_not_consecutive", int'(sv_prev), 0);
      end
      sv_prev = select_valid;
   endtask

   task automatic move(input int x, input int y);
      cursor_x = 7'(x);
      cursor_y = 7'(y);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_hover"}, int'(hover_square), 31);
      chk({tag, "_hover_valid"}, int'(hover_valid), 0);
      chk({tag, "_select_valid"}, int'(select_valid), 0);
      chk({tag, "_select_square"}, int'(select_square), 31);
      chk({tag, "_state"}, int'(state), 0);
   endtask

   initial begin
      int p0;
      int hold_len;

      vecs[0]  = '{7'd10, 7'd10, 5'd0};
      vecs[1]  = '{7'd29, 7'd10, 5'd0};
      vecs[2]  = '{7'd30, 7'd10, 5'd31};
      vecs[3]  = '{7'd54, 7'd54, 5'd8};
      vecs[4]  = '{7'd32, 7'd54, 5'd7};
      vecs[5]  = '{7'd76, 7'd10, 5'd9};
      vecs[6]  = '{7'd95, 7'd29, 5'd9};
      vecs[7]  = '{7'd96, 7'd10, 5'd31};
      vecs[8]  = '{7'd9,  7'd10, 5'd31};
      vecs[9]  = '{7'd73, 7'd73, 5'd8};
      vecs[10] = '{7'd74, 7'd73, 5'd31};
      vecs[11] = '{7'd40, 7'd40, 5'd4};
      vecs[12] = '{7'd10, 7'd32, 5'd3};
      vecs[13] = '{7'd76, 7'd30, 5'd31};

      reset = 1'b1; enable = 1'b1; btn_left = 1'b0;
      move(40, 40);
      tick(); tick();
      chk_reset_vals("reset");

      reset = 1'b0;
      for (int i = 0; i < 14; i++) begin
         move(int'(vecs[i].x), int'(vecs[i].y));
         tick();
         chk($sformatf("hover_%0d_%0d", vecs[i].x, vecs[i].y), int'(hover_square), int'(vecs[i].sq));
         chk($sformatf("hover_valid_%0d_%0d", vecs[i].x, vecs[i].y), int'(hover_valid),
             (vecs[i].sq != 5'd31) ? 1 : 0);
      end

      // Drag away from square 0 into square 1.
      p0 = pulses;
      move(12, 12); tick();
      btn_left = 1'b1; tick();
      chk("drag_armed", int'(state), 1);
      move(35, 12); tick(); tick();
      chk("drag_cancel", int'(state), 2);
      btn_left = 1'b0; tick();
      chk("drag_idle", int'(state), 0);
      tick();
      chk("drag_no_pulse", pulses - p0, 0);
      chk("drag_select_square", int'(select_square), 31);

      // Press on empty space, then move onto a square and release.
      p0 = pulses;
      move(0, 0); tick();
      btn_left = 1'b1; tick();
      chk("nosq_cancel", int'(state), 2);
      move(12, 12); tick(); tick();
      chk("nosq_still_cancel", int'(state), 2);
      btn_left = 1'b0; tick(); tick();
      chk("nosq_idle", int'(state), 0);
      chk("nosq_no_pulse", pulses - p0, 0);

      // Button held across reset release never counts as a press.
      p0 = pulses;
      reset = 1'b1; btn_left = 1'b1; tick(); tick();
      reset = 1'b0; tick(); tick();
      chk("held_reset_idle", int'(state), 0);
      btn_left = 1'b0; tick(); tick();
      chk("held_reset_state", int'(state), 0);
      chk("held_reset_no_pulse", pulses - p0, 0);

      // Clean click at square 4.
      p0 = pulses;
      move(40, 40); tick();
      btn_left = 1'b1; tick();
      chk("click_armed", int'(state), 1);
      repeat (4) tick();
      chk("click_still_armed", int'(state), 1);
      btn_left = 1'b0; tick();
      chk("click_pulse", int'(select_valid), 1);
      chk("click_square", int'(select_square), 4);
      chk("click_holdoff", int'(state), 3);
      hold_len = 1;
      tick();
      chk("click_pulse_one_cycle", int'(select_valid), 0);
      for (int i = 0; i < 40 && state == 2'd3; i++) begin
         hold_len++;
         tick();
      end
      chk("click_holdoff_len", hold_len, 16);
      chk("click_back_idle", int'(state), 0);
      chk("click_one_pulse", pulses - p0, 1);
      chk("click_square_held", int'(select_square), 4);

      // Second click within holdoff is ignored.
      p0 = pulses;
      btn_left = 1'b1; tick();
      btn_left = 1'b0; tick();
      chk("hold_first_pulse", int'(select_valid), 1);
      btn_left = 1'b1; tick();
      chk("hold_ignores_press", int'(state), 3);
      btn_left = 1'b0; tick();
      repeat (20) tick();
      chk("hold_state_idle", int'(state), 0);
      chk("hold_single_pulse", pulses - p0, 1);

      // Button held when holdoff expires lands in CANCEL.
      btn_left = 1'b1; tick();
      btn_left = 1'b0; tick();
      btn_left = 1'b1;
      repeat (20) tick();
      chk("hold_exit_cancel", int'(state), 2);
      btn_left = 1'b0; tick();
      chk("hold_exit_idle", int'(state), 0);

      // enable dropped while ARMED.
      p0 = pulses;
      move(12, 12); tick();
      btn_left = 1'b1; tick();
      chk("en_armed", int'(state), 1);
      enable = 1'b0; tick();
      chk("en_idle", int'(state), 0);
      btn_left = 1'b0; tick();
      enable = 1'b1; tick(); tick();
      chk("en_no_pulse", pulses - p0, 0);
      chk("en_state", int'(state), 0);

      // reset while ARMED restores every reset value.
      p0 = pulses;
      btn_left = 1'b1; tick();
      chk("rst_armed", int'(state), 1);
      reset = 1'b1; tick();
      chk_reset_vals("rst_mid");
      reset = 1'b0; btn_left = 1'b0; tick(); tick();
      chk("rst_no_pulse", pulses - p0, 0);
      chk("rst_state", int'(state), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
